// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART receiver: FSM state codes,
// data-length and parity encodings.
package uart_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_PARITY    = 3'd3;
    localparam logic [2:0] ST_STOP      = 3'd4;
    localparam logic [2:0] ST_WAIT_IDLE = 3'd5;

    typedef enum logic [1:0] {
        NB_5 = 2'b00,
        NB_6 = 2'b01,
        NB_7 = 2'b10,
        NB_8 = 2'b11
    } num_bits_e;

    typedef enum logic {
        PAR_EVEN = 1'b0,
        PAR_ODD  = 1'b1
    } parity_e;

    function automatic logic [3:0] num_bits(input logic [1:0] code);
        case (num_bits_e'(code))
            NB_5:    return 4'd5;
            NB_6:    return 4'd6;
            NB_7:    return 4'd7;
            default: return 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; a push into a full FIFO is
// accepted only when a pop frees a slot in the same cycle.
module uart_sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uart_rx_buffered.sv
// Oversampling UART receiver with majority-vote sampling, false-start and
// break detection, framing/parity flags and an RX FIFO with valid/ready pop.
module uart_rx_buffered
    import uart_pkg::*;
#(
    parameter int OVS        = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_tick,
    input  logic [1:0]       i_num_bit_data,
    input  logic             i_stop_bit,
    input  logic             i_parity_en,
    input  logic             i_parity_type,
    input  logic             i_rx_serial,
    output logic [7:0]       o_data,
    output logic             o_parity_err,
    output logic             o_frame_err,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_rx_done,
    output logic             o_break,
    output logic             o_overrun,
    input  logic             i_clr_err,
    output logic [CNT_W-1:0] o_fifo_count
);

    localparam int TCNT_W = $clog2(OVS);
    localparam logic [TCNT_W-1:0] SMP_A     = TCNT_W'(OVS / 2 - 1);
    localparam logic [TCNT_W-1:0] SMP_B     = TCNT_W'(OVS / 2);
    localparam logic [TCNT_W-1:0] SMP_C     = TCNT_W'(OVS / 2 + 1);
    localparam logic [TCNT_W-1:0] TICK_LAST = TCNT_W'(OVS - 1);

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    logic              rx_sync_p0;
    logic              rx_sync_p1;
    logic [2:0]        state;
    logic [TCNT_W-1:0] tick_cnt;
    logic [2:0]        bit_idx;
    logic              stop_idx;
    logic [3:0]        nbits_q;
    logic              stop2_q;
    logic              par_en_q;
    logic              par_type_q;
    logic [7:0]        data_q;
    logic              par_bit_q;
    logic              frame_err_q;
    logic              smp_a_q;
    logic              smp_b_q;
    logic              done_p1;
    logic              push_p1;
    logic              brk_p1;
    logic              bit_val;
    logic              mid_tick;
    logic              start_det;
    logic              last_data;
    logic              last_stop;
    logic              brk_cond;
    logic              par_err;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [9:0]        fifo_rdata;

    // Stage p0/p1: two-flop synchroniser on the asynchronous line
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sync_p0 <= 1'b1;
            rx_sync_p1 <= 1'b1;
        end else begin
            rx_sync_p0 <= i_rx_serial;
            rx_sync_p1 <= rx_sync_p0;
        end
    end

    assign bit_val   = maj3(smp_a_q, smp_b_q, rx_sync_p1);
    assign mid_tick  = rx_tick && (tick_cnt == SMP_C);
    assign start_det = rx_tick && (state == ST_IDLE) && !rx_sync_p1;
    assign last_data = (bit_idx == 3'(nbits_q - 4'd1));
    assign last_stop = !stop2_q || stop_idx;
    assign brk_cond  = (data_q == 8'd0) && !(par_en_q && par_bit_q) && !bit_val;
    assign par_err   = par_en_q && ((^data_q) ^ par_bit_q ^ (parity_e'(par_type_q) == PAR_ODD));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            tick_cnt <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            done_p1  <= 1'b0;
            push_p1  <= 1'b0;
            brk_p1   <= 1'b0;
        end else begin
            done_p1 <= 1'b0;
            push_p1 <= 1'b0;
            brk_p1  <= 1'b0;
            if (rx_tick) begin
                tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
                case (state)
                    ST_IDLE: begin
                        tick_cnt <= '0;
                        if (!rx_sync_p1) state <= ST_START;
                    end
                    ST_START: begin
                        if (tick_cnt == SMP_C && bit_val) begin
                            state <= ST_IDLE;
                        end else if (tick_cnt == TICK_LAST) begin
                            state    <= ST_DATA;
                            bit_idx  <= '0;
                            stop_idx <= 1'b0;
                        end
                    end
                    ST_DATA: begin
                        if (tick_cnt == TICK_LAST) begin
                            if (last_data) state <= par_en_q ? ST_PARITY : ST_STOP;
                            else           bit_idx <= bit_idx + 1'b1;
                        end
                    end
                    ST_PARITY: begin
                        if (tick_cnt == TICK_LAST) state <= ST_STOP;
                    end
                    ST_STOP: begin
                        // The frame closes at the mid-bit of the last stop bit
                        if (tick_cnt == SMP_C) begin
                            if (!stop_idx && brk_cond) begin
                                state   <= ST_WAIT_IDLE;
                                done_p1 <= 1'b1;
                                brk_p1  <= 1'b1;
                            end else if (last_stop) begin
                                state   <= (frame_err_q || !bit_val) ? ST_WAIT_IDLE : ST_IDLE;
                                done_p1 <= 1'b1;
                                push_p1 <= 1'b1;
                            end
                        end else if (tick_cnt == TICK_LAST) begin
                            stop_idx <= 1'b1;
                        end
                    end
                    ST_WAIT_IDLE: begin
                        tick_cnt <= '0;
                        if (rx_sync_p1) state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (start_det) begin
            nbits_q     <= num_bits(i_num_bit_data);
            stop2_q     <= i_stop_bit;
            par_en_q    <= i_parity_en;
            par_type_q  <= i_parity_type;
            data_q      <= '0;
            frame_err_q <= 1'b0;
        end
        if (rx_tick && tick_cnt == SMP_A) smp_a_q <= rx_sync_p1;
        if (rx_tick && tick_cnt == SMP_B) smp_b_q <= rx_sync_p1;
        if (mid_tick) begin
            case (state)
                ST_DATA:   data_q[bit_idx] <= bit_val;
                ST_PARITY: par_bit_q <= bit_val;
                ST_STOP:   if (!bit_val) frame_err_q <= 1'b1;
                default:   ;
            endcase
        end
    end

    assign pop = o_valid & i_ready;

    uart_sync_fifo #(
        .WIDTH (10),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_p1),
        .pop   (pop),
        .wdata ({frame_err_q, par_err, data_q}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (o_fifo_count)
    );

    assign o_valid   = !fifo_empty;
    assign o_rx_done = done_p1;
    assign {o_frame_err, o_parity_err, o_data} = o_valid ? fifo_rdata : 10'd0;

    // Sticky status: a new event in the same cycle as a clear keeps the flag set
    always_ff @(posedge clk) begin
        if (rst) begin
            o_break   <= 1'b0;
            o_overrun <= 1'b0;
        end else begin
            if (brk_p1)         o_break <= 1'b1;
            else if (i_clr_err) o_break <= 1'b0;
            if (push_p1 && fifo_full && !pop) o_overrun <= 1'b1;
            else if (i_clr_err)               o_overrun <= 1'b0;
        end
    end

endmodule
